hex_entry: RTL

HEX_ENTRY -- requirements
Module: hex_entry

---
 rtl/hex_entry.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/hex_entry.sv
// Debounced hex-digit entry: shifts di into a 4-digit register on each accepted button press.
// Optional autorepeat while the button is held is enabled by defining HEX_ENTRY_AUTOREPEAT_EN.
module hex_entry #(
  parameter int unsigned DEB_MS     = 20,
  parameter int unsigned REP_DLY_MS = 500,
  parameter int unsigned REP_MS     = 100
) (
  input  logic        clk,
  input  logic        R,
  input  logic        ce1ms,
  input  logic        btn,
  input  logic        btn_clr,
  input  logic [3:0]  di,
  output logic [15:0] dat,
  output logic [2:0]  nd,
  output logic        key,
  output logic        pressed
);

  localparam logic [7:0] DebLast = 8'(DEB_MS - 1);

  typedef enum logic [1:0] {StRel, StChkP, StPrs, StChkR} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        btn_m_q, btn_s_q, clr_m_q, clr_s_q;
  logic [15:0] dat_q, dat_d;
  logic [2:0]  nd_q, nd_d;
  logic        key_q, key_d;
  logic        deb_acc, rep_acc, accept;

  always_ff @(posedge clk) begin
    if (R) begin
      btn_m_q <= 1'b0;
      btn_s_q <= 1'b0;
      clr_m_q <= 1'b0;
      clr_s_q <= 1'b0;
    end else begin
      btn_m_q <= btn;
      btn_s_q <= btn_m_q;
      clr_m_q <= btn_clr;
      clr_s_q <= clr_m_q;
    end
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state_q <= StRel;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    deb_acc = 1'b0;
    unique case (state_q)
      StRel: begin
        if (btn_s_q) begin
          state_d = StChkP;
          cnt_d   = '0;
        end
      end
      StChkP: begin
        if (!btn_s_q) begin
          state_d = StRel;
        end else if (ce1ms) begin
          if (cnt_q == DebLast) begin
            state_d = StPrs;
            deb_acc = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      StPrs: begin
        if (!btn_s_q) begin
          state_d = StChkR;
          cnt_d   = '0;
        end
      end
      StChkR: begin
        if (btn_s_q) begin
          state_d = StPrs;
        end else if (ce1ms) begin
          if (cnt_q == DebLast) begin
            state_d = StRel;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
    endcase
  end

  always_comb begin
    pressed = (state_q == StPrs) || (state_q == StChkR);
  end

`ifdef HEX_ENTRY_AUTOREPEAT_EN
  localparam logic [9:0] RepDlyLast = 10'(REP_DLY_MS - 1);
  localparam logic [9:0] RepLast    = 10'(REP_MS - 1);

  logic [9:0] rep_q, rep_d;
  logic       rep_first_q, rep_first_d;

  // Cleared only on a fresh press; a bounce back from StChkR resumes the count.
  always_comb begin
    rep_d       = rep_q;
    rep_first_d = rep_first_q;
    rep_acc     = 1'b0;
    if (state_q == StChkP && state_d == StPrs) begin
      rep_d       = '0;
      rep_first_d = 1'b1;
    end else if (state_q == StPrs && ce1ms) begin
      if (rep_q == (rep_first_q ? RepDlyLast : RepLast)) begin
        rep_acc     = 1'b1;
        rep_d       = '0;
        rep_first_d = 1'b0;
      end else begin
        rep_d = rep_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (R) begin
      rep_q       <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_q       <= rep_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  assign rep_acc = 1'b0;
`endif

  assign accept = deb_acc | rep_acc;

  // Clear wins over a simultaneous acceptance but leaves the debounce FSM alone.
  always_comb begin
    dat_d = dat_q;
    nd_d  = nd_q;
    key_d = 1'b0;
    if (clr_s_q) begin
      dat_d = '0;
      nd_d  = '0;
    end else if (accept) begin
      dat_d = {dat_q[11:0], di};
      nd_d  = (nd_q == 3'd4) ? 3'd4 : nd_q + 3'd1;
      key_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (R) begin
      dat_q <= '0;
      nd_q  <= '0;
      key_q <= 1'b0;
    end else begin
      dat_q <= dat_d;
      nd_q  <= nd_d;
      key_q <= key_d;
    end
  end

  assign dat = dat_q;
  assign nd  = nd_q;
  assign key = key_q;

endmodule
